ibuffer_warp_param: RTL
=======================

Name: ibuffer_warp_param

Overview:
Parametrised per-warp instruction buffer. It sits between the dual-decode ID stage and the issue unit (IU) / operand collector (OC), and is the successor of the fixed 4-entry warp buffer. It adds:
- configurable depth and payload width;
- a single packed decode payload;
- SIMT flush of unissued entries;
- an overflow error flag;
- a sticky warp-done state after EXIT.

It keeps memory-replay tracking with per-entry private active masks (PAM).

Parameters:
NUM_THREADS, 8, threads per warp; width of the active mask.
DEPTH, 4, entry count; power of 2, at least 2.
PAYLOAD_W, 64, packed decoded-instruction bundle width (instr, regs, ALUop, imm, control bits).
Derived localparam PTR_W = $clog2(DEPTH)+1 (the extra bit is the wrap bit).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
if_valid  in  1  one fetch in flight IF->ID
req_if  out  1  permission to fetch
wr_valid  in  1  decoded instruction valid (ID0|ID1 already merged)
wr_payload  in  PAYLOAD_W  decoded bundle
wr_mem  in  1  LW/SW, i.e. replayable
wr_sw  in  1  store (1) / load (0)
wr_exit  in  1  EXIT instruction
wr_am  in  NUM_THREADS  SIMT active mask
flush  in  1  SIMT drop: discard all unissued entries
issue_req  out  1  request to IU
issue_grant  in  1  IU grant; same-cycle response to issue_req
issue_replay  out  1  current request is a replay
issue_payload  out  PAYLOAD_W  bundle of requested entry
issue_am  out  NUM_THREADS  PAM of requested entry
issue_scb_id  out  2  stored Scb ID (replay only)
scb_full  in  1  scoreboard full
scb_dependent  in  1  RP entry has a hazard
scb_empty  in  1  no outstanding Scb entries
scb_id  in  2  Scb entry allocated on first issue
scb_alloc  out  1  first-issue grant; allocate Scb entry
scb_alloc_replayable  out  1  allocated entry is LW/SW (incomplete)
fb_pos_valid  in  1  positive feedback for the outstanding memory op
fb_pos_mask  in  NUM_THREADS  threads served
fb_zero_valid  in  1  miss served; replay needed
replay_done  out  1  outstanding memory op complete (1-cycle pulse)
replay_done_scb_id  out  2  Scb ID to clear
replay_done_sw  out  1  store/load type of the completed op
exit_req  out  1  EXIT request to IU/RAU
exit_grant  in  1  EXIT accepted
done  out  1  sticky warp finished
ovf_err  out  1  sticky write-while-full
occupancy  out  PTR_W  WP-IRP

Behaviour:
Pointers (PTR_W bits, wrap bit):
- WP: write pointer.
- RP: next first-issue entry.
- IRP: oldest retained entry; IRP <= RP <= WP.
- Full when WP-IRP == DEPTH.
- Reset: all pointers 0; valid/replay-pending bits 0; done=0; ovf_err=0. All outputs 0, except req_if = 1 (when if_valid=0).

Write path:
- wr_en = wr_valid & !flush & !full & !done. Stores payload, flags and PAM=wr_am at WP; sets valid; WP++.
- wr_valid while full: write dropped, ovf_err set.

Fetch credit:
- req_if = !done & (occupancy + if_valid + wr_en) < DEPTH, combinational.

Issue priority (combinational):
1. IRP!=RP and IRP entry replay-pending, or feedback arriving this cycle that leaves its PAM nonzero or is fb_zero_valid → replay request (issue_replay=1).
2. Otherwise, RP entry valid, !exit, !scb_full, !scb_dependent, and (IRP==RP or RP entry non-replayable) → first-issue request.
   - This limits the buffer to at most one outstanding replayable op.

Grant handling:
- First-issue grant: scb_alloc=1; scb_id latched into the entry; RP++.
  - Non-replayable entry: invalidated.
  - Replayable entry: stays valid.
- Replay grant: clears replay-pending; PAM unchanged.

Feedback (applies to the IRP entry only; ignored when IRP==RP):
- Positive feedback: PAM &= ~fb_pos_mask.
  - Result 0 → replay_done pulse the same cycle; entry invalidated.
  - Otherwise → replay-pending set.
- fb_zero_valid: sets replay-pending.

IRP movement:
- When IRP==RP, IRP tracks RP's next value.
- Otherwise, IRP advances one entry per cycle while the IRP entry is invalid.

Exit:
- exit_req = RP entry valid & exit & IRP==RP & scb_empty.
- exit_grant: entry invalidated, RP/IRP advance, done set.
- After done, writes are ignored.

Flush:
- WP <= RP_next and all unissued entries are invalidated.
- The outstanding replay entry and the same-cycle grant are honoured.
- A same-cycle write is dropped.

Simultaneous events:
- Write, grant, feedback and flush in one cycle all apply.
- Invalidation wins over set on the same entry.
- Reset mid-replay discards all state.

Optional Feature:
IB_BYPASS_EN

With the macro defined:
- When occupancy==0 and wr_en with !wr_exit, issue_req asserts the same cycle with wr_payload/wr_am.
- On grant with a non-replayable instruction: nothing is stored; WP and RP are unchanged.
- On grant with a replayable instruction: the entry is stored with RP = WP+1.

Without the macro:
- Minimum write-to-issue latency is 1 cycle.

Test Plan:
- DEPTH=4, 4 back-to-back ALU writes, grant held low → occupancy=4, req_if=0; 5th write sets ovf_err=1, occupancy stays 4.
- LW with am=0xFF issued (scb_id=2); fb_pos_mask=0x0F → issue_replay=1, issue_am=0xF0 next request; replay granted, then fb_pos_mask=0xF0 → replay_done=1, replay_done_scb_id=2, replay_done_sw=0.
- LW outstanding, then second SW at RP → no first-issue request; following ALU instruction behind the SW waits; ALU directly at RP issues.
- 3 unissued entries plus outstanding SW, flush=1 → occupancy=1, WP=RP; later positive feedback completes the SW.
- EXIT at RP with scb_empty=0 → exit_req=0; scb_empty=1 → exit_req=1; exit_grant → done=1, req_if=0, wr_valid ignored.
- IB_BYPASS_EN, empty buffer, ALU write with grant the same cycle → issue_payload==wr_payload, occupancy stays 0.

Source files
------------

// File: rtl/ibuffer_warp_param_if.sv
// rtl/ibuffer_warp_param_if.sv - signal bundle between ID, per-warp instruction buffer and IU/OC
// Purpose: groups the fetch-credit, write, issue, scoreboard, memory-feedback and exit
//          handshakes of one warp's instruction buffer.
// Modports:
//   master - surrounding pipeline: drives if_valid, wr_*, flush, issue_grant, scb_* inputs,
//            fb_* feedback and exit_grant; observes everything the buffer produces.
//   slave  - ibuffer_warp_param: drives req_if, issue_*, scb_alloc*, replay_done*,
//            exit_req, done, ovf_err and occupancy.
interface ibuffer_warp_param_if #(
  parameter int NUM_THREADS = 8,
  parameter int DEPTH       = 4,
  parameter int PAYLOAD_W   = 64
);
  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic                   if_valid;
  logic                   req_if;
  logic                   wr_valid;
  logic [PAYLOAD_W-1:0]   wr_payload;
  logic                   wr_mem;
  logic                   wr_sw;
  logic                   wr_exit;
  logic [NUM_THREADS-1:0] wr_am;
  logic                   flush;
  logic                   issue_req;
  logic                   issue_grant;
  logic                   issue_replay;
  logic [PAYLOAD_W-1:0]   issue_payload;
  logic [NUM_THREADS-1:0] issue_am;
  logic [1:0]             issue_scb_id;
  logic                   scb_full;
  logic                   scb_dependent;
  logic                   scb_empty;
  logic [1:0]             scb_id;
  logic                   scb_alloc;
  logic                   scb_alloc_replayable;
  logic                   fb_pos_valid;
  logic [NUM_THREADS-1:0] fb_pos_mask;
  logic                   fb_zero_valid;
  logic                   replay_done;
  logic [1:0]             replay_done_scb_id;
  logic                   replay_done_sw;
  logic                   exit_req;
  logic                   exit_grant;
  logic                   done;
  logic                   ovf_err;
  logic [PTR_W-1:0]       occupancy;

  modport master (
    output if_valid, wr_valid, wr_payload, wr_mem, wr_sw, wr_exit, wr_am, flush,
           issue_grant, scb_full, scb_dependent, scb_empty, scb_id,
           fb_pos_valid, fb_pos_mask, fb_zero_valid, exit_grant,
    input  req_if, issue_req, issue_replay, issue_payload, issue_am, issue_scb_id,
           scb_alloc, scb_alloc_replayable, replay_done, replay_done_scb_id,
           replay_done_sw, exit_req, done, ovf_err, occupancy
  );

  modport slave (
    input  if_valid, wr_valid, wr_payload, wr_mem, wr_sw, wr_exit, wr_am, flush,
           issue_grant, scb_full, scb_dependent, scb_empty, scb_id,
           fb_pos_valid, fb_pos_mask, fb_zero_valid, exit_grant,
    output req_if, issue_req, issue_replay, issue_payload, issue_am, issue_scb_id,
           scb_alloc, scb_alloc_replayable, replay_done, replay_done_scb_id,
           replay_done_sw, exit_req, done, ovf_err, occupancy
  );
endinterface

// File: rtl/ibuffer_warp_param.sv
// rtl/ibuffer_warp_param.sv - parametrised per-warp instruction buffer with memory replay tracking
// Purpose: holds decoded instructions of one warp between ID and IU/OC, issues them in order,
//          keeps at most one replayable LW/SW retained with its private active mask until the
//          memory system reports every thread served, supports SIMT flush and sticky EXIT.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - ibuffer_warp_param_if.slave (write, fetch credit, issue, scoreboard, feedback, exit)
// Optional feature macro: IB_BYPASS_EN (same-cycle issue of a write into an empty buffer).
module ibuffer_warp_param #(
  parameter int NUM_THREADS = 8,
  parameter int DEPTH       = 4,
  parameter int PAYLOAD_W   = 64
) (
  input logic                clk,
  input logic                rst,
  ibuffer_warp_param_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  logic [PAYLOAD_W-1:0]   ent_payload [DEPTH];
  logic [NUM_THREADS-1:0] ent_am      [DEPTH];
  logic [1:0]             ent_scb     [DEPTH];
  logic [DEPTH-1:0]       ent_mem, ent_sw, ent_exit, ent_valid, ent_rpend;

  logic [PTR_W-1:0] wp, rp, irp, rp_next, occ, flush_cnt;
  logic [IDX_W-1:0] wi, ri, ii;
  logic             done_q, ovf_q;

  assign wi  = wp[IDX_W-1:0];
  assign ri  = rp[IDX_W-1:0];
  assign ii  = irp[IDX_W-1:0];
  assign occ = wp - irp;

  logic full, outstanding, rp_has, wr_en;
  assign full        = (occ == DEPTH_P);
  assign outstanding = (irp != rp);
  assign rp_has      = (rp != wp) & ent_valid[ri];
  assign wr_en       = bus.wr_valid & ~bus.flush & ~full & ~done_q;

  // Feedback only concerns the retained memory op sitting at IRP.
  logic                   fb_live, fb_pos, fb_zero, complete;
  logic [NUM_THREADS-1:0] pam_fb;
  assign fb_live  = outstanding & ent_valid[ii];
  assign fb_pos   = fb_live & bus.fb_pos_valid;
  assign fb_zero  = fb_live & bus.fb_zero_valid;
  assign pam_fb   = fb_pos ? (ent_am[ii] & ~bus.fb_pos_mask) : ent_am[ii];
  assign complete = fb_pos & (pam_fb == '0);

  logic replay_req, fi_req, byp_req, exit_req;
  assign replay_req = fb_live & ~complete & (ent_rpend[ii] | fb_pos | fb_zero);
  // A replayable entry may only first-issue when nothing else is retained.
  assign fi_req     = ~replay_req & rp_has & ~ent_exit[ri] & ~bus.scb_full & ~bus.scb_dependent
                      & (~outstanding | ~ent_mem[ri]);
  assign exit_req   = rp_has & ent_exit[ri] & ~outstanding & bus.scb_empty & ~done_q;

`ifdef IB_BYPASS_EN
  assign byp_req = (occ == '0) & wr_en & ~bus.wr_exit & ~bus.scb_full & ~bus.scb_dependent;
`else
  assign byp_req = 1'b0;
`endif

  logic fi_grant, byp_grant, rpl_grant, exit_take, byp_keep, store, retain;
  assign fi_grant  = bus.issue_grant & fi_req;
  assign byp_grant = bus.issue_grant & byp_req;
  assign rpl_grant = bus.issue_grant & replay_req;
  assign exit_take = bus.exit_grant & exit_req;
  // A bypassed LW/SW is still stored so it can be replayed; a bypassed ALU op never lands.
  assign byp_keep  = byp_grant & bus.wr_mem;
  assign store     = wr_en & ~(byp_grant & ~bus.wr_mem);
  // Issuing a replayable entry pins IRP on it instead of following RP.
  assign retain    = (fi_grant & ent_mem[ri]) | byp_keep;
  assign rp_next   = rp + {{(PTR_W-1){1'b0}}, (fi_grant | exit_take | byp_keep)};
  assign flush_cnt = wp - rp_next;

  // Entries between the post-grant RP and WP are the unissued ones a flush drops.
  logic [DEPTH-1:0] kill;
  always_comb begin
    kill = '0;
    for (int i = 0; i < DEPTH; i++)
      kill[i] = bus.flush & ({1'b0, IDX_W'(i) - rp_next[IDX_W-1:0]} < flush_cnt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp        <= '0;
      rp        <= '0;
      irp       <= '0;
      ent_valid <= '0;
      ent_rpend <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (store) begin
        ent_valid[wi] <= 1'b1;
        ent_rpend[wi] <= 1'b0;
      end
      if (rpl_grant)
        ent_rpend[ii] <= 1'b0;
      else if (fb_zero | (fb_pos & ~complete))
        ent_rpend[ii] <= 1'b1;
      // Invalidations come last so they win over any set on the same entry.
      if (fi_grant & ~ent_mem[ri]) ent_valid[ri] <= 1'b0;
      if (exit_take)               ent_valid[ri] <= 1'b0;
      if (complete) begin
        ent_valid[ii] <= 1'b0;
        ent_rpend[ii] <= 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (kill[i]) begin
          ent_valid[i] <= 1'b0;
          ent_rpend[i] <= 1'b0;
        end
      end
      wp <= bus.flush ? rp_next : wp + {{(PTR_W-1){1'b0}}, store};
      rp <= rp_next;
      if (!outstanding) begin
        if (!retain) irp <= rp_next;
      end else if (!ent_valid[ii]) begin
        irp <= irp + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      done_q <= done_q | exit_take;
      ovf_q  <= ovf_q | (bus.wr_valid & full & ~done_q);
    end
  end

  // Payload storage needs no reset: nothing reads it while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (store) begin
      ent_payload[wi] <= bus.wr_payload;
      ent_am[wi]      <= bus.wr_am;
      ent_mem[wi]     <= bus.wr_mem;
      ent_sw[wi]      <= bus.wr_sw;
      ent_exit[wi]    <= bus.wr_exit;
      if (byp_keep) ent_scb[wi] <= bus.scb_id;
    end
    if (fi_grant) ent_scb[ri] <= bus.scb_id;
    if (fb_pos)   ent_am[ii]  <= pam_fb;
  end

  logic [PAYLOAD_W-1:0]   iss_payload;
  logic [NUM_THREADS-1:0] iss_am;
  always_comb begin
    iss_payload = '0;
    iss_am      = '0;
    if (replay_req) begin
      iss_payload = ent_payload[ii];
      iss_am      = pam_fb;
    end else if (fi_req) begin
      iss_payload = ent_payload[ri];
      iss_am      = ent_am[ri];
    end else if (byp_req) begin
      iss_payload = bus.wr_payload;
      iss_am      = bus.wr_am;
    end
  end

  logic [PTR_W:0] credit_sum;
  assign credit_sum = {1'b0, occ} + {{PTR_W{1'b0}}, bus.if_valid} + {{PTR_W{1'b0}}, wr_en};

  assign bus.req_if               = ~done_q & (credit_sum < {1'b0, DEPTH_P});
  assign bus.issue_req            = replay_req | fi_req | byp_req;
  assign bus.issue_replay         = replay_req;
  assign bus.issue_payload        = iss_payload;
  assign bus.issue_am             = iss_am;
  assign bus.issue_scb_id         = replay_req ? ent_scb[ii] : 2'b00;
  assign bus.scb_alloc            = fi_grant | byp_grant;
  assign bus.scb_alloc_replayable = (fi_grant & ent_mem[ri]) | byp_keep;
  assign bus.replay_done          = complete;
  assign bus.replay_done_scb_id   = complete ? ent_scb[ii] : 2'b00;
  assign bus.replay_done_sw       = complete & ent_sw[ii];
  assign bus.exit_req             = exit_req;
  assign bus.done                 = done_q;
  assign bus.ovf_err              = ovf_q;
  assign bus.occupancy            = occ;
endmodule
